// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller: controller state
// encoding, size defaults and the opcode constants used by the core's halt logic.
package instr_mem_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [7:0] OP_ENDOP = 8'd28;

  function automatic logic is_endop(input logic [7:0] opcode);
    return opcode == OP_ENDOP;
  endfunction

endpackage

// File: rtl/instr_ld_counter.sv
// Loader write pointer: advances two bytes per accepted word and clears on
// return to LOAD. It saturates at a full memory instead of wrapping.
module instr_ld_counter
  import instr_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [ADDR_WIDTH:0] prog_len,
  output logic                load_full
);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
    end else if (inc && !load_full) begin
      wr_ptr_d = wr_ptr_q + (ADDR_WIDTH + 1)'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // The pointer moves in steps of two from zero, so it lands exactly on 2^ADDR_WIDTH.
  assign load_full = wr_ptr_q[ADDR_WIDTH];
  assign prog_len  = wr_ptr_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Shares the single instruction memory port between the program loader (LOAD)
// and the core fetch stage (RUN) with a one-cycle registered read path.
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  input  logic [2*DATA_WIDTH-1:0] ld_data,
  output logic                    ld_ready,
  input  logic                    ld_done,
  input  logic                    ld_restart,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_ready,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_instr,
  input  logic                    cpu_halt,
  output logic                    running,
  output logic [ADDR_WIDTH:0]     prog_len,
  output logic                    load_full,
  output logic                    mem_we,
  output logic [2*DATA_WIDTH-1:0] mem_w_instr,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_instr
);

  state_e state_q, state_d;
  logic   fetch_valid_q, fetch_valid_d;
  logic   ld_accept, fetch_accept, ctr_clr;

  instr_ld_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ld_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (ld_accept),
    .clr      (ctr_clr),
    .prog_len (prog_len),
    .load_full(load_full)
  );

  always_comb begin
    state_d       = state_q;
    ctr_clr       = 1'b0;
    ld_accept     = (state_q == LOAD) && !load_full && ld_valid;
    fetch_accept  = (state_q == RUN) && fetch_req;
    fetch_valid_d = fetch_accept;
    case (state_q)
      LOAD: begin
        // A word accepted alongside ld_done makes the program non-empty.
        if (ld_done && ((prog_len != '0) || ld_accept)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cpu_halt || ld_restart) begin
          state_d = LOAD;
          ctr_clr = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign ld_ready    = (state_q == LOAD) && !load_full;
  assign fetch_ready = (state_q == RUN);
  assign running     = (state_q == RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_valid_q ? mem_r_instr : '0;

  assign mem_we      = ld_accept;
  assign mem_w_addr  = ld_accept ? prog_len[ADDR_WIDTH-1:0] : '0;
  assign mem_w_instr = ld_accept ? ld_data : '0;
  assign mem_r_addr  = fetch_addr;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl with a byte-wide instruction memory model attached.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_done, ld_restart, fetch_req, cpu_halt;
  logic [15:0] ld_data;
  logic [7:0]  fetch_addr;
  logic        ld_ready, fetch_ready, fetch_valid, running, load_full, mem_we;
  logic [7:0]  fetch_instr, mem_w_addr, mem_r_addr, mem_r_instr;
  logic [8:0]  prog_len;
  logic [15:0] mem_w_instr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  always #5 clk = ~clk;

  instr_mem_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_restart (ld_restart),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .cpu_halt   (cpu_halt),
    .running    (running),
    .prog_len   (prog_len),
    .load_full  (load_full),
    .mem_we     (mem_we),
    .mem_w_instr(mem_w_instr),
    .mem_w_addr (mem_w_addr),
    .mem_r_addr (mem_r_addr),
    .mem_r_instr(mem_r_instr)
  );

  // Instruction memory: 16-bit write of two bytes, registered byte read every cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_w_addr]        <= mem_w_instr[7:0];
      mem[mem_w_addr + 8'd1] <= mem_w_instr[15:8];
    end
    mem_r_instr <= mem[mem_r_addr];
  end

  typedef struct {
    logic        ldv;
    logic [15:0] ldd;
    logic        ldn;
    logic        frq;
    logic [7:0]  fad;
    logic        hlt;
    logic        e_ldr;
    logic        e_run;
    logic [8:0]  e_len;
    logic        e_we;
    logic [7:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_fv;
    logic [7:0]  e_fi;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle();
    ld_valid = 1'b0; ld_data = '0; ld_done = 1'b0; ld_restart = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; cpu_halt = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ld_ready"},    32'(ld_ready), 32'd1);
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'd0);
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, " fetch_instr"}, 32'(fetch_instr), 32'd0);
    chk({tag, " running"},     32'(running), 32'd0);
    chk({tag, " prog_len"},    32'(prog_len), 32'd0);
    chk({tag, " load_full"},   32'(load_full), 32'd0);
    chk({tag, " mem_we"},      32'(mem_we), 32'd0);
    chk({tag, " mem_w_instr"}, 32'(mem_w_instr), 32'd0);
    chk({tag, " mem_w_addr"},  32'(mem_w_addr), 32'd0);
    chk({tag, " mem_r_addr"},  32'(mem_r_addr), 32'(fetch_addr));
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) d++;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [17];
    logic        prev_req;
    logic [7:0]  prev_addr;
    logic [15:0] w;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'hA5;
      exp_mem[i] = 8'hA5;
    end

    // ldv ldd ldn frq fad hlt | ldr run len we wa wd fv fi
    tbl[0]  = '{0, 16'h0000, 0, 0, 8'h00, 0,  1, 0, 9'd0, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[1]  = '{1, 16'h0D18, 0, 0, 8'h00, 0,  1, 0, 9'd0, 1, 8'd0, 16'h0D18, 0, 8'h00};
    tbl[2]  = '{1, 16'h1C01, 0, 0, 8'h00, 0,  1, 0, 9'd2, 1, 8'd2, 16'h1C01, 0, 8'h00};
    tbl[3]  = '{0, 16'h0000, 1, 0, 8'h00, 0,  1, 0, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[4]  = '{0, 16'h0000, 0, 1, 8'h00, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[5]  = '{0, 16'h0000, 0, 1, 8'h01, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 1, 8'h18};
    tbl[6]  = '{0, 16'h0000, 0, 1, 8'h02, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 1, 8'h0D};
    tbl[7]  = '{0, 16'h0000, 0, 1, 8'h03, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 1, 8'h01};
    tbl[8]  = '{0, 16'h0000, 0, 0, 8'h00, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 1, 8'h1C};
    tbl[9]  = '{0, 16'h0000, 0, 0, 8'h00, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[10] = '{1, 16'hFFFF, 0, 0, 8'h00, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[11] = '{0, 16'h0000, 1, 0, 8'h00, 0,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[12] = '{0, 16'h0000, 0, 1, 8'h01, 1,  0, 1, 9'd4, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[13] = '{0, 16'h0000, 0, 1, 8'h00, 0,  1, 0, 9'd0, 0, 8'd0, 16'h0000, 1, 8'h0D};
    tbl[14] = '{0, 16'h0000, 0, 0, 8'h00, 0,  1, 0, 9'd0, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[15] = '{0, 16'h0000, 1, 0, 8'h00, 0,  1, 0, 9'd0, 0, 8'd0, 16'h0000, 0, 8'h00};
    tbl[16] = '{0, 16'h0000, 0, 0, 8'h00, 0,  1, 0, 9'd0, 0, 8'd0, 16'h0000, 0, 8'h00};

    idle();
    fetch_addr = 8'h37;
    rst_n = 1'b0;
    #2;
    chk_reset_vals("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Basic load, fetch pipeline, wrong-state inputs, halt with a fetch in flight.
    for (int unsigned r = 0; r < 17; r++) begin
      if (r != 0) @(negedge clk);
      idle();
      ld_valid = tbl[r].ldv; ld_data = tbl[r].ldd; ld_done = tbl[r].ldn;
      fetch_req = tbl[r].frq; fetch_addr = tbl[r].fad; cpu_halt = tbl[r].hlt;
      #1;
      chk($sformatf("row%0d ld_ready", r),    32'(ld_ready), 32'(tbl[r].e_ldr));
      chk($sformatf("row%0d fetch_ready", r), 32'(fetch_ready), 32'(tbl[r].e_run));
      chk($sformatf("row%0d running", r),     32'(running), 32'(tbl[r].e_run));
      chk($sformatf("row%0d prog_len", r),    32'(prog_len), 32'(tbl[r].e_len));
      chk($sformatf("row%0d mem_we", r),      32'(mem_we), 32'(tbl[r].e_we));
      chk($sformatf("row%0d mem_w_addr", r),  32'(mem_w_addr), 32'(tbl[r].e_wa));
      chk($sformatf("row%0d mem_w_instr", r), 32'(mem_w_instr), 32'(tbl[r].e_wd));
      chk($sformatf("row%0d fetch_valid", r), 32'(fetch_valid), 32'(tbl[r].e_fv));
      chk($sformatf("row%0d fetch_instr", r), 32'(fetch_instr), 32'(tbl[r].e_fi));
      chk($sformatf("row%0d mem_r_addr", r),  32'(mem_r_addr), 32'(tbl[r].fad));
      if (tbl[r].e_we) begin
        exp_mem[tbl[r].e_wa]        = tbl[r].ldd[7:0];
        exp_mem[tbl[r].e_wa + 8'd1] = tbl[r].ldd[15:8];
      end
    end
    @(negedge clk);
    idle();
    chk("table mem bytes 0..3", {mem[0], mem[1], mem[2], mem[3]}, 32'h180D011C);
    chk("table mem diffs", 32'(mem_diffs()), 32'd0);

    // Full memory: 128 random words back to back, then a refused 129th.
    for (int unsigned i = 0; i < 128; i++) begin
      if (i != 0) @(negedge clk);
      w = 16'($urandom);
      ld_valid = 1'b1; ld_data = w;
      #1;
      chk($sformatf("full wr%0d addr", i), {23'd0, mem_we, mem_w_addr}, {23'd1, 8'(2 * i)});
      exp_mem[8'(2 * i)]     = w[7:0];
      exp_mem[8'(2 * i + 1)] = w[15:8];
    end
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 16'hBEEF;
    #1;
    chk("full load_full", 32'(load_full), 32'd1);
    chk("full ld_ready",  32'(ld_ready), 32'd0);
    chk("full prog_len",  32'(prog_len), 32'd256);
    chk("full 129th mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    idle();
    ld_done = 1'b1;
    #1;
    chk("full mem diffs", 32'(mem_diffs()), 32'd0);
    chk("full still load", 32'(running), 32'd0);

    // Random fetch traffic against the byte image the loader wrote.
    prev_req = 1'b0; prev_addr = '0;
    for (int unsigned i = 0; i < 200; i++) begin
      @(negedge clk);
      idle();
      fetch_req  = ($urandom_range(3) != 0);
      fetch_addr = 8'($urandom);
      #1;
      chk("rand running", 32'(running), 32'd1);
      chk("rand fetch_valid", 32'(fetch_valid), 32'(prev_req));
      chk("rand fetch_instr", 32'(fetch_instr), prev_req ? 32'(exp_mem[prev_addr]) : 32'd0);
      prev_req = fetch_req; prev_addr = fetch_addr;
    end

    // Async reset with a fetch result pending.
    @(negedge clk);
    idle();
    fetch_req = 1'b1; fetch_addr = 8'h10;
    @(negedge clk);
    idle();
    #1;
    chk("midfetch fetch_valid before rst", 32'(fetch_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midfetch");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midfetch mem untouched", 32'(mem_diffs()), 32'd0);

    // Word and ld_done together from an empty program.
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 16'h2233; ld_done = 1'b1;
    #1;
    chk("simul we+addr", {23'd0, mem_we, mem_w_addr}, {23'd1, 8'd0});
    exp_mem[0] = 8'h33; exp_mem[1] = 8'h22;
    @(negedge clk);
    idle();
    #1;
    chk("simul running", 32'(running), 32'd1);
    chk("simul prog_len", 32'(prog_len), 32'd2);
    chk("simul mem", 32'(mem_diffs()), 32'd0);

    // Halt and restart in the same cycle act as one return to LOAD.
    @(negedge clk);
    cpu_halt = 1'b1; ld_restart = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("halt+restart running", 32'(running), 32'd0);
    chk("halt+restart prog_len", 32'(prog_len), 32'd0);
    @(negedge clk);
    #1;
    chk("halt+restart stays load", {30'd0, running, ld_ready}, 32'd1);

    // Async reset mid-load at wr_ptr=6, then reload from address 0.
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      w = 16'($urandom);
      ld_valid = 1'b1; ld_data = w;
      exp_mem[8'(2 * i)] = w[7:0]; exp_mem[8'(2 * i + 1)] = w[15:8];
    end
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 16'h5A5A;
    #1;
    chk("midload wr addr 6", 32'(mem_w_addr), 32'd6);
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0;
    #1;
    chk_reset_vals("midload");
    @(negedge clk);
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = 16'h7788;
    #1;
    chk("reload addr", {23'd0, mem_we, mem_w_addr}, {23'd1, 8'd0});
    exp_mem[0] = 8'h88; exp_mem[1] = 8'h77;
    @(negedge clk);
    idle();
    #1;
    chk("reload prog_len", 32'(prog_len), 32'd2);
    chk("reload mem", 32'(mem_diffs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Controller that sits in front of the single-core instruction memory and shares its one port between two requesters: the program loader, which writes 16-bit instruction pairs, and the core's fetch stage, which reads bytes. It sequences a LOAD phase, where the loader fills memory from address 0 upward two bytes per word, and a RUN phase, where the core fetches with fixed one-cycle read latency. A core halt or a loader restart returns the block to LOAD for the next program.

## Interface
Parameters:
- DATA_WIDTH, 8, instruction byte width
- ADDR_WIDTH, 8, instruction memory address width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  loader word present
- ld_data  in  2*DATA_WIDTH  instruction pair; [7:0] goes to addr, [15:8] to addr+1
- ld_ready  out  1  loader word accepted when ld_valid & ld_ready
- ld_done  in  1  pulse: program complete, enter RUN
- ld_restart  in  1  pulse: abort RUN, re-enter LOAD at address 0
- fetch_req  in  1  core read request
- fetch_addr  in  ADDR_WIDTH  byte address to read
- fetch_ready  out  1  fetch accepted when fetch_req & fetch_ready
- fetch_valid  out  1  fetch_instr valid this cycle
- fetch_instr  out  DATA_WIDTH  fetched byte
- cpu_halt  in  1  pulse from core on ENDOP (opcode 28)
- running  out  1  high in RUN; core start/enable
- prog_len  out  ADDR_WIDTH+1  bytes loaded in the current program
- load_full  out  1  memory filled; further words refused
- mem_we  out  1  to memory write enable
- mem_w_instr  out  2*DATA_WIDTH  to memory write data
- mem_w_addr  out  ADDR_WIDTH  to memory write address
- mem_r_addr  out  ADDR_WIDTH  to memory read address
- mem_r_instr  in  DATA_WIDTH  from memory registered read data

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- LOAD: ld_ready = ~load_full. On accept, mem_we=1, mem_w_addr=wr_ptr, mem_w_instr=ld_data, and wr_ptr += 2.
- prog_len = wr_ptr. Its width is ADDR_WIDTH+1, so a full memory reads 256.
- If a word is accepted at wr_ptr = 2^ADDR_WIDTH-2, load_full is set next cycle and ld_ready drops. wr_ptr never wraps.
- LOAD → RUN on ld_done. If ld_valid is accepted in the same cycle as ld_done, the write completes first and the transition still happens.
- ld_done with prog_len=0 is ignored; the block stays in LOAD.
- RUN: ld_ready=0 and fetch_ready=1. mem_we=0 throughout, so memory reads every cycle. mem_r_addr = fetch_addr combinationally.
- An accepted fetch gives fetch_valid=1 and fetch_instr=mem_r_instr in the next cycle. Back-to-back fetches are allowed, one per cycle.
- RUN → LOAD on cpu_halt or ld_restart. The transition clears wr_ptr and load_full.
- A fetch accepted in the transition cycle still returns its fetch_valid next cycle.
- cpu_halt and ld_restart asserted together are treated as a single return to LOAD.
- fetch_req in LOAD: fetch_ready=0, no fetch_valid.
- ld_valid, ld_done and cpu_halt in the wrong state have no effect.
- Out of reset, LOAD must start with mem_we=0 until a word is accepted, so the memory's power-up contents are not overwritten.

## Timing
- Reset values: ld_ready=1, fetch_ready=0, fetch_valid=0, fetch_instr=0, running=0, prog_len=0, load_full=0, mem_we=0, mem_w_instr=0, mem_w_addr=0, mem_r_addr=fetch_addr.
- Write latency: 0 cycles. mem_we, mem_w_addr and mem_w_instr are combinational from the accept.
- Read latency: 1 cycle from fetch accept to fetch_valid.
- State change takes effect on the next edge. running is registered and equals (state==RUN).
- Reset mid-load or mid-fetch: state returns to LOAD immediately and asynchronously. Any pending fetch_valid is dropped. Memory contents are untouched.

## Structure
- Shared package holds:
  - state encoding: LOAD=1'b0, RUN=1'b1
  - opcode constants, at minimum ENDOP=8'd28, used by the core's halt logic
  - the DATA_WIDTH/ADDR_WIDTH defaults
- Optional sub-module: instr_ld_counter, holding wr_ptr, prog_len and load_full. The FSM, fetch pipeline register and muxing stay in instr_mem_ctrl.
- Bench instantiates instr_mem_ctrl together with the instruction memory.

## Test plan
- **Basic load:** after reset, send ld_data 0x0D18, 0x1C01, then ld_done → writes at addresses 0 and 2; memory bytes 0..3 = 0x18, 0x0D, 0x01, 0x1C; prog_len=4; running=1 next cycle.
- **Fetch pipeline:** in RUN, fetch_req on addresses 0, 1, 2, 3 in consecutive cycles → fetch_valid in 4 consecutive cycles with 0x18, 0x0D, 0x01, 0x1C.
- **Full memory:** 128 back-to-back words → load_full=1 and ld_ready=0 after the 128th; prog_len=256; a 129th ld_valid is not written.
- **Simultaneous events:** ld_valid with ld_done in the same cycle writes the word and enters RUN. ld_done with prog_len=0 stays in LOAD.
- **Return to LOAD:** cpu_halt in RUN with a fetch accepted in the same cycle → fetch_valid next cycle, running=0, prog_len=0, ld_ready=1. A fetch_req in LOAD gets no fetch_valid.
- **Async reset:** rst_n low mid-load at wr_ptr=6 → all outputs take their reset values immediately. A reload then starts writing at address 0.
